// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: valid/ready handshake with a 2-entry skid buffer
// (MAIN drives outputs, SKID absorbs one instruction under backpressure).
module ex_mem_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic                  in_zero,
  input  logic [DATA_W-1:0]     in_store_data,
  input  logic [DATA_W-1:0]     in_branch_target,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic                  in_branch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [DATA_W-1:0]     out_branch_target,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic                  out_branch_taken
);

  localparam int ENT_W = 3*DATA_W + REG_ADDR_W + 6;

  logic [ENT_W-1:0]      r_main;
  logic [ENT_W-1:0]      r_skid;
  logic                  r_main_valid;
  logic                  r_skid_valid;

  logic [ENT_W-1:0]      w_in_entry;
  logic                  w_acc;
  logic                  w_pop;
  logic                  w_zero;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_reg_write;
  logic                  w_mem_to_reg;
  logic                  w_branch;

  assign w_in_entry = {in_alu_result, in_zero, in_store_data, in_branch_target, in_rd,
                       in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch};

  assign in_ready = !r_skid_valid;
  assign w_acc    = in_valid & in_ready;
  assign w_pop    = r_main_valid & out_ready;

  // Flush only drops valid bits; field contents are left stale on purpose.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_acc) begin
        r_main       <= w_in_entry;
        r_main_valid <= 1'b1;
      end
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_acc) begin
        r_main <= w_in_entry;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid       <= w_in_entry;
      r_skid_valid <= 1'b1;
    end
  end

  assign {out_alu_result, w_zero, out_store_data, out_branch_target, out_rd,
          w_mem_read, w_mem_write, w_reg_write, w_mem_to_reg, w_branch} = r_main;

  assign out_valid        = r_main_valid;
  assign out_mem_read     = r_main_valid & w_mem_read;
  assign out_mem_write    = r_main_valid & w_mem_write;
  assign out_reg_write    = r_main_valid & w_reg_write;
  assign out_mem_to_reg   = r_main_valid & w_mem_to_reg;
  assign out_branch_taken = r_main_valid & w_branch & w_zero;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the 64-bit ALU (execute) and data memory / writeback.
- Captures the ALU result, the Zero flag, store data and the memory/writeback control bits for one instruction per cycle.
- Uses a valid/ready handshake with a 2-entry skid buffer, so memory-side backpressure never drops or reorders an instruction.
- Provides a synchronous flush so that branch-taken can squash wrong-path instructions.

Parameters:
- DATA_W, 64, width of ALU result, store data and branch target.
- REG_ADDR_W, 5, width of destination register index.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  execute stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_alu_result  input  DATA_W  ALUresult from the ALU.
- in_zero  input  1  Zero from the ALU.
- in_store_data  input  DATA_W  rs2 value for sd.
- in_branch_target  input  DATA_W  PC + imm for beq.
- in_rd  input  REG_ADDR_W  destination register.
- in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch  input  1 each  decoded control.
- out_valid  output  1  main entry holds a live instruction.
- out_ready  input  1  memory stage consumes the main entry.
- out_alu_result, out_store_data, out_branch_target  output  DATA_W  fields of the main entry.
- out_rd  output  REG_ADDR_W  field of the main entry.
- out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  output  1  fields of the main entry, ANDed with out_valid.
- out_branch_taken  output  1  out_valid & branch & zero of the main entry.

Behaviour:
- Storage: MAIN entry (drives outputs) and SKID entry; each entry has a valid bit plus all fields.
- in_ready is registered: in_ready = !skid_valid.
- Accept condition: acc = in_valid & in_ready. Pop condition: pop = out_valid & out_ready.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N (out_valid=1). Throughput is 1/cycle while out_ready=1.
- Transitions per edge (flush/reset not asserted):
  - main empty, acc: input goes to MAIN.
  - main full, pop, skid empty, acc: input goes to MAIN.
  - main full, pop, skid empty, no acc: MAIN becomes invalid.
  - main full, !pop, acc: input goes to SKID; in_ready=0 next cycle.
  - main full, pop, skid full: SKID moves to MAIN, SKID becomes invalid; acc cannot occur.
  - main full, !pop, skid full: hold everything.
- FIFO order is always preserved. SKID is never valid while MAIN is invalid.
- Control gating: out_mem_write, out_mem_read, out_reg_write, out_mem_to_reg and out_branch_taken are 0 whenever out_valid=0. Data fields may hold stale values when out_valid=0.
- Flush:
  - Next edge clears both valid bits; in_ready=1 afterwards.
  - An input presented in the flush cycle is dropped.
  - A pop in the flush cycle still completes; the consumer sees that cycle's outputs.
- Reset:
  - Clears both valid bits and all fields to 0; in_ready=1.
  - Reset mid-operation discards held instructions.
  - Reset has priority over flush.
- No arithmetic in this block; fields pass bit-exact, widths unchanged.

Test Plan:
- Reset, then in_valid=1 for one cycle with alu_result=64'h10, rd=5, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_alu_result=64'h10, out_rd=5, out_reg_write=1; following cycle out_valid=0, out_reg_write=0.
- Stream A=1, B=2, C=3 back-to-back with out_ready=1 -> outputs 1, 2, 3 on consecutive cycles; in_ready stays 1 throughout.
- out_ready=0 while sending A=7 then B=8 -> MAIN=7, SKID=8, in_ready=0, C held at input. Raise out_ready -> 7, then 8, then C appear in order with no loss or duplication.
- branch=1, zero=1, branch_target=64'h400 -> out_branch_taken=1, out_branch_target=64'h400. Same instruction with zero=0 -> out_branch_taken=0.
- Fill MAIN and SKID, assert flush together with in_valid=1 (value 9) -> next cycle out_valid=0, in_ready=1, value 9 never appears, out_mem_write=0.
- Hold two valid entries with mem_write=1, assert reset for one cycle -> out_valid=0, all outputs 0, in_ready=1; no write strobe issued after reset.
